vme_slave_responder: RTL and testbench

//  VMEbus slave (responder) for A24/D16 cycles from another VME master. Decodes the

---
 rtl/vme_slave_responder.sv | 160 ++++++++++++++++
 tb/tb_vme_slave_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_slave_responder.sv
// VMEbus A24/D16 slave: decodes window + AM, runs a req/ack local-bus handshake
// and drives DTACK*/BERR* and the D16 transceiver controls.
module vme_slave_responder #(
  parameter logic [22:0] BASE_ADDR      = 23'h400000,
  parameter logic [22:0] ADDR_MASK      = 23'h7F0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vme_as,
  input  logic [1:0]  vme_ds,
  input  logic        vme_lword,
  input  logic        vme_write,
  input  logic [5:0]  vme_address_mod,
  input  logic [22:0] vme_address,
  input  logic        vme_iack,
  output logic        vme_dtack,
  output logic        vme_berr,
  output logic        data_oe,
  output logic        data_dir,
  output logic        local_req,
  output logic        local_write,
  output logic [22:0] local_addr,
  output logic [1:0]  local_be,
  input  logic        local_ack,
  input  logic        local_err,
  output logic        status_led
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;

  // AS* and both DS* strobes are asynchronous; each bit gets its own 2-flop chain.
  logic [2:0] async_bits;
  logic [2:0] sync_bits;
  logic       as_s;
  logic [1:0] ds_s;

  assign async_bits = {vme_as, vme_ds};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic stage1_reg;
      logic stage2_reg;
      always_ff @(posedge clock) begin
        if (!reset) begin
          stage1_reg <= 1'b1;
          stage2_reg <= 1'b1;
        end else begin
          stage1_reg <= async_bits[gi];
          stage2_reg <= stage1_reg;
        end
      end
      assign sync_bits[gi] = stage2_reg;
    end
  endgenerate

  assign as_s = sync_bits[2];
  assign ds_s = sync_bits[1:0];

  logic match;
  logic am_ok;
  logic strobe;

  assign match  = ((vme_address & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && vme_iack;
  assign am_ok  = (vme_address_mod == 6'h39) || (vme_address_mod == 6'h3A) ||
                  (vme_address_mod == 6'h3D) || (vme_address_mod == 6'h3E);
  assign strobe = !as_s && (ds_s != 2'b11);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      vme_dtack   <= 1'b1;
      vme_berr    <= 1'b1;
      data_oe     <= 1'b1;
      data_dir    <= 1'b1;
      local_req   <= 1'b0;
      local_write <= 1'b0;
      local_addr  <= '0;
      local_be    <= '0;
      status_led  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (strobe) begin
            if (match && am_ok && vme_lword) begin
              state_reg   <= ST_ACCESS;
              count_reg   <= '0;
              local_req   <= 1'b1;
              local_addr  <= vme_address;
              local_write <= ~vme_write;
              local_be    <= ~ds_s;
              data_dir    <= ~vme_write;
              data_oe     <= 1'b0;
              status_led  <= 1'b1;
            end else if (match) begin
              // Selected but D32 or an unsupported AM: refuse with BERR, no local access.
              state_reg  <= ST_DONE;
              vme_berr   <= 1'b0;
              status_led <= 1'b1;
            end else begin
              state_reg <= ST_DONE;
            end
          end
        end

        ST_ACCESS: begin
          if (count_reg != CNT_MAX) begin
            count_reg <= count_reg + 1'b1;
          end
          if (local_err) begin
            state_reg <= ST_DONE;
            vme_berr  <= 1'b0;
            local_req <= 1'b0;
          end else if (local_ack) begin
            state_reg <= ST_DONE;
            vme_dtack <= 1'b0;
            local_req <= 1'b0;
          end else if (count_reg == CNT_LAST) begin
            state_reg <= ST_DONE;
            vme_berr  <= 1'b0;
            local_req <= 1'b0;
          end
        end

        ST_DONE: begin
          // Wait for the master to lift both data strobes; AS may stay low for RMW.
          if (ds_s == 2'b11) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            vme_dtack   <= 1'b1;
            vme_berr    <= 1'b1;
            data_oe     <= 1'b1;
            data_dir    <= 1'b1;
            local_write <= 1'b0;
            local_addr  <= '0;
            local_be    <= '0;
            status_led  <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_slave_responder.sv
// Directed bench for vme_slave_responder; window placed at byte address 0x400000.
module tb_vme_slave_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        vme_as;
  logic [1:0]  vme_ds;
  logic        vme_lword;
  logic        vme_write;
  logic [5:0]  vme_address_mod;
  logic [22:0] vme_address;
  logic        vme_iack;
  logic        vme_dtack;
  logic        vme_berr;
  logic        data_oe;
  logic        data_dir;
  logic        local_req;
  logic        local_write;
  logic [22:0] local_addr;
  logic [1:0]  local_be;
  logic        local_ack;
  logic        local_err;
  logic        status_led;

  int n_tests = 0;
  int n_fail  = 0;

  vme_slave_responder #(
    .BASE_ADDR      (23'h200000),
    .ADDR_MASK      (23'h7F0000),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .vme_as          (vme_as),
    .vme_ds          (vme_ds),
    .vme_lword       (vme_lword),
    .vme_write       (vme_write),
    .vme_address_mod (vme_address_mod),
    .vme_address     (vme_address),
    .vme_iack        (vme_iack),
    .vme_dtack       (vme_dtack),
    .vme_berr        (vme_berr),
    .data_oe         (data_oe),
    .data_dir        (data_dir),
    .local_req       (local_req),
    .local_write     (local_write),
    .local_addr      (local_addr),
    .local_be        (local_be),
    .local_ack       (local_ack),
    .local_err       (local_err),
    .status_led      (status_led)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk23(input string tag, input logic [22:0] obs, input logic [22:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_ctl(input string tag, input logic e_dtack, input logic e_berr,
                           input logic e_oe, input logic e_req);
    chk1({tag, ".dtack"}, vme_dtack, e_dtack);
    chk1({tag, ".berr"},  vme_berr,  e_berr);
    chk1({tag, ".oe"},    data_oe,   e_oe);
    chk1({tag, ".req"},   local_req, e_req);
  endtask

  task automatic check_bus(input string tag, input logic [22:0] e_addr, input logic [1:0] e_be,
                           input logic e_wr, input logic e_dir, input logic e_led);
    chk23({tag, ".addr"}, local_addr,  e_addr);
    chk2({tag, ".be"},    local_be,    e_be);
    chk1({tag, ".write"}, local_write, e_wr);
    chk1({tag, ".dir"},   data_dir,    e_dir);
    chk1({tag, ".led"},   status_led,  e_led);
  endtask

  task automatic start_cycle(input logic [22:0] addr, input logic [5:0] am,
                             input logic wr_n, input logic lword_n, input logic [1:0] ds);
    vme_address     = addr;
    vme_address_mod = am;
    vme_write       = wr_n;
    vme_lword       = lword_n;
    vme_as          = 1'b0;
    vme_ds          = ds;
  endtask

  task automatic end_cycle();
    vme_as = 1'b1;
    vme_ds = 2'b11;
  endtask

  initial begin
    reset = 1'b0; vme_as = 1'b0; vme_ds = 2'b00; vme_lword = 1'b1; vme_write = 1'b1;
    vme_address_mod = 6'h00; vme_address = '0; vme_iack = 1'b1;
    local_ack = 1'b0; local_err = 1'b0;

    // 1: reset held with strobes asserted
    step(2);
    check_ctl("reset", 1'b1, 1'b1, 1'b1, 1'b0);
    check_bus("reset", 23'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    end_cycle();
    step(2);
    reset = 1'b1;
    step(3);
    check_ctl("post_reset", 1'b1, 1'b1, 1'b1, 1'b0);

    // 2: word write, AM 3D, byte address 0x400010
    start_cycle(23'h200008, 6'h3D, 1'b0, 1'b1, 2'b00);
    step(2);
    chk1("wr.req_early", local_req, 1'b0);
    step(1);
    check_ctl("wr.req", 1'b1, 1'b1, 1'b0, 1'b1);
    check_bus("wr.req", 23'h200008, 2'b11, 1'b1, 1'b1, 1'b1);
    step(3);
    check_ctl("wr.wait", 1'b1, 1'b1, 1'b0, 1'b1);
    local_ack = 1'b1;
    step(1);
    local_ack = 1'b0;
    check_ctl("wr.ack", 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    chk1("wr.dtack_hold", vme_dtack, 1'b0);
    end_cycle();
    step(2);
    chk1("wr.dtack_2clk", vme_dtack, 1'b0);
    step(1);
    check_ctl("wr.release", 1'b1, 1'b1, 1'b1, 1'b0);
    check_bus("wr.release", 23'h0, 2'b00, 1'b0, 1'b1, 1'b0);

    // 3: odd-byte read, AM 39
    start_cycle(23'h2000A0, 6'h39, 1'b1, 1'b1, 2'b10);
    step(3);
    check_ctl("rd.req", 1'b1, 1'b1, 1'b0, 1'b1);
    check_bus("rd.req", 23'h2000A0, 2'b01, 1'b0, 1'b0, 1'b1);
    local_ack = 1'b1;
    step(1);
    local_ack = 1'b0;
    check_ctl("rd.ack", 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    chk1("rd.oe_hold", data_oe, 1'b0);
    end_cycle();
    step(3);
    check_ctl("rd.release", 1'b1, 1'b1, 1'b1, 1'b0);
    chk1("rd.dir_idle", data_dir, 1'b1);

    // 4: read with no local_ack -> timeout BERR
    start_cycle(23'h200100, 6'h3A, 1'b1, 1'b1, 2'b00);
    step(3);
    chk1("to.req", local_req, 1'b1);
    step(63);
    check_ctl("to.before", 1'b1, 1'b1, 1'b0, 1'b1);
    step(1);
    check_ctl("to.berr", 1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    check_ctl("to.hold", 1'b1, 1'b0, 1'b0, 1'b0);
    end_cycle();
    step(2);
    chk1("to.berr_2clk", vme_berr, 1'b0);
    step(1);
    check_ctl("to.release", 1'b1, 1'b1, 1'b1, 1'b0);

    // 5: byte address 0x200000 is outside the window
    start_cycle(23'h100000, 6'h39, 1'b1, 1'b1, 2'b00);
    step(5);
    check_ctl("miss", 1'b1, 1'b1, 1'b1, 1'b0);
    check_bus("miss", 23'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    end_cycle();
    step(3);
    start_cycle(23'h200040, 6'h3E, 1'b0, 1'b1, 2'b01);
    step(3);
    check_ctl("after_miss.req", 1'b1, 1'b1, 1'b0, 1'b1);
    check_bus("after_miss.req", 23'h200040, 2'b10, 1'b1, 1'b1, 1'b1);
    local_ack = 1'b1;
    step(1);
    local_ack = 1'b0;
    chk1("after_miss.dtack", vme_dtack, 1'b0);
    end_cycle();
    step(3);
    chk1("after_miss.release", vme_dtack, 1'b1);

    // 6a: D32 request inside the window
    start_cycle(23'h200010, 6'h39, 1'b1, 1'b0, 2'b00);
    step(3);
    check_ctl("d32", 1'b1, 1'b0, 1'b1, 1'b0);
    step(2);
    chk1("d32.no_req", local_req, 1'b0);
    end_cycle();
    step(3);
    chk1("d32.release", vme_berr, 1'b1);

    // 6b: unsupported AM 29 inside the window
    start_cycle(23'h200010, 6'h29, 1'b1, 1'b1, 2'b00);
    step(3);
    check_ctl("bad_am", 1'b1, 1'b0, 1'b1, 1'b0);
    end_cycle();
    step(3);
    chk1("bad_am.release", vme_berr, 1'b1);

    // 6c: ack and err together; late ack in DONE must not raise DTACK
    start_cycle(23'h200020, 6'h39, 1'b1, 1'b1, 2'b00);
    step(3);
    chk1("err.req", local_req, 1'b1);
    local_ack = 1'b1;
    local_err = 1'b1;
    step(1);
    local_err = 1'b0;
    check_ctl("err.both", 1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    local_ack = 1'b0;
    chk1("err.late_ack", vme_dtack, 1'b1);
    end_cycle();
    step(3);
    check_ctl("err.release", 1'b1, 1'b1, 1'b1, 1'b0);

    // reset in the middle of a cycle releases DTACK at that edge
    start_cycle(23'h200030, 6'h39, 1'b1, 1'b1, 2'b00);
    step(3);
    local_ack = 1'b1;
    step(1);
    local_ack = 1'b0;
    chk1("mid.dtack", vme_dtack, 1'b0);
    reset = 1'b0;
    step(1);
    check_ctl("mid.reset", 1'b1, 1'b1, 1'b1, 1'b0);
    check_bus("mid.reset", 23'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    end_cycle();
    step(2);
    reset = 1'b1;
    step(3);
    check_ctl("mid.after", 1'b1, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
